// File: rtl/image_streamer.sv
// Image source for the MNIST CNN pipeline: buffers one image, streams it one pixel per clock, then collects the decision.
// Pixel i is valid one edge after start is sampled plus i; no backpressure, and host writes are refused while a run is in progress.
module image_streamer #(
  parameter int IMG_PIXELS     = 784,
  parameter int PIX_BITS       = 8,
  parameter int ADDR_BITS      = 10,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_BITS   = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [PIX_BITS-1:0]  wr_data,
  input  logic                 start,
  input  logic [3:0]           dec_in,
  input  logic                 dec_valid,
  output logic [PIX_BITS-1:0]  data_out,
  output logic                 pix_valid,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           result,
  output logic                 timeout,
  output logic                 wr_reject
);

  localparam logic [ADDR_BITS:0]      NUM_PIX  = (ADDR_BITS+1)'(IMG_PIXELS);
  localparam logic [ADDR_BITS-1:0]    LAST_IDX = ADDR_BITS'(IMG_PIXELS - 1);
  localparam logic [TIMEOUT_BITS-1:0] TO_LIMIT = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [PIX_BITS-1:0]     img_buf [IMG_PIXELS];
  logic [ADDR_BITS-1:0]    idx;
  logic [TIMEOUT_BITS-1:0] tcnt;

  logic start_run;
  logic emit;
  logic dec_take;
  logic to_fire;
  logic wr_ok;
  logic wr_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    emit      = 1'b0;
    dec_take  = 1'b0;
    to_fire   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_STREAM;
          start_run = 1'b1;
        end
      end
      S_STREAM: begin
        emit = 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A decision arriving on the last allowed cycle still counts.
        if (dec_valid) begin
          dec_take  = 1'b1;
          state_nxt = S_DONE;
        end else if (tcnt == TO_LIMIT) begin
          to_fire   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          state_nxt = S_STREAM;
          start_run = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign wr_busy = (state == S_STREAM) || (state == S_WAIT);
  assign wr_ok   = wr_en && !wr_busy && ({1'b0, wr_addr} < NUM_PIX);

  // The image buffer is deliberately not reset so its contents survive an abort.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      img_buf[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 4'h0;
      timeout   <= 1'b0;
      wr_reject <= 1'b0;
      idx       <= '0;
      tcnt      <= '0;
    end else begin
      busy      <= (state_nxt == S_STREAM) || (state_nxt == S_WAIT);
      done      <= (state_nxt == S_DONE);
      wr_reject <= wr_en && wr_busy;
      pix_valid <= emit;

      if (start_run) begin
        idx     <= '0;
        tcnt    <= '0;
        timeout <= 1'b0;
      end

      if (emit) begin
        data_out <= img_buf[idx];
        if (idx != LAST_IDX) begin
          idx <= idx + 1'b1;
        end
      end

      if (state == S_WAIT && tcnt != TO_LIMIT) begin
        tcnt <= tcnt + 1'b1;
      end

      if (dec_take) begin
        result  <= dec_in;
        timeout <= 1'b0;
      end else if (to_fire) begin
        result  <= 4'hF;
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: doc/image_streamer.md
Name: image_streamer

Overview:
- Host-side driver for the CNN MNIST pipeline. It is the source end of the pixel interface consumed by conv1_layer, and the sink end of the comparator decision output.
- Holds one 28x28 8-bit image in an internal buffer, loaded through a simple write port.
- On start, streams the pixels one per clock in raster order with a valid strobe.
- Then waits for the comparator's valid decision, latches it and reports done, or reports timeout.

Parameters:
IMG_PIXELS, 784, number of pixels per image
PIX_BITS, 8, pixel width
ADDR_BITS, 10, buffer address / pixel counter width
TIMEOUT_CYCLES, 4096, max cycles in WAIT_RESULT before abort
TIMEOUT_BITS, 13, timeout counter width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  host buffer write strobe
wr_addr  input  ADDR_BITS  buffer write address
wr_data  input  PIX_BITS  pixel value to write
start  input  1  begin streaming the buffered image (level sampled per clock)
dec_in  input  4  decision from comparator
dec_valid  input  1  decision valid from comparator
data_out  output  PIX_BITS  pixel to conv1_layer data_in
pix_valid  output  1  data_out holds a pixel of the current image
busy  output  1  state is STREAM or WAIT_RESULT
done  output  1  result available (state DONE)
result  output  4  latched decision
timeout  output  1  last run ended without a decision
wr_reject  output  1  one-cycle pulse: write attempted while busy

Behaviour:
- Reset: asynchronous on rst_n low. State IDLE; data_out=0, pix_valid=0, busy=0, done=0, result=0, timeout=0, wr_reject=0; pixel and timeout counters=0. Buffer contents are not reset; they are undefined until written.
- Writes: wr_en with wr_addr<IMG_PIXELS is accepted in IDLE and DONE and writes the buffer that edge. wr_addr>=IMG_PIXELS is dropped silently. wr_en in STREAM or WAIT_RESULT does not write and pulses wr_reject for 1 cycle.
- FSM states: IDLE, STREAM, WAIT_RESULT, DONE.
- IDLE: start=1 -> STREAM, idx<=0, timeout<=0.
- STREAM: each edge, data_out<=buf[idx], pix_valid<=1, idx<=idx+1. After the edge that emits idx=IMG_PIXELS-1 -> WAIT_RESULT. start is ignored.
- Stream timing: if start is sampled at edge k, pixel i is on data_out with pix_valid=1 after edge k+1+i, for i=0..783. pix_valid drops after edge k+785, and data_out holds the last pixel. Exactly IMG_PIXELS valid cycles, no gaps.
- WAIT_RESULT: timeout counter increments each cycle.
  - dec_valid=1: result<=dec_in, timeout<=0 -> DONE.
  - Counter reaches TIMEOUT_CYCLES-1 with no dec_valid: result<=4'hF, timeout<=1 -> DONE.
  - If dec_valid arrives on the same cycle the counter reaches its limit, dec_valid wins.
- DONE: done=1; result and timeout are held. start=1 -> STREAM (restart: done<=0, idx<=0, timeout<=0); otherwise stay.
- dec_valid in IDLE, STREAM or DONE is ignored; result is unchanged.
- busy and done are registered and derived from the next state, so they change on the same edge as the state.
- Reset asserted mid-stream or mid-wait aborts immediately: pix_valid=0 and state IDLE. The buffer keeps its contents, so a new start replays the same image.
- Counter widths: idx is ADDR_BITS wide and never wraps past IMG_PIXELS-1. The timeout counter saturates, with no wrap.

Test Plan:
- Reset, then write buf[i]=i[7:0] for i=0..783, then pulse start for one cycle. Required: exactly 784 consecutive pix_valid cycles, data_out sequence 0,1,...,255,0,...,15; first valid pixel one edge after start is sampled; busy=1 throughout.
- After the stream, drive dec_in=4'd3 with dec_valid=1 for one cycle 200 cycles later. Required: result=3, done=1, timeout=0, busy=0 on the next edge; both held until the next start.
- No dec_valid after the stream. Required: done=1, timeout=1, result=4'hF exactly TIMEOUT_CYCLES cycles after WAIT_RESULT entry.
- wr_en to addr 5 during STREAM. Required: wr_reject is a 1-cycle pulse, buf[5] is unchanged on replay, and a dec_valid during STREAM leaves result unchanged.
- Assert rst_n=0 at pixel 400. Required: pix_valid=0 and state IDLE immediately. After release, start replays pixels 0..783 with the original contents.
- dec_valid on the final timeout cycle with dec_in=7. Required: result=7, timeout=0. A start held high in DONE restarts streaming on the next edge.
